// File: rtl/instr_encoder.sv
// instr_encoder: packs LEGv8 requests into 32-bit words and buffers them in a 2-entry FIFO; INSTR_ENCODER_COUNT_EN adds a pop counter.
module instr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_class,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rn,
    input  logic [4:0]  in_rm,
    input  logic [18:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        err
`ifdef INSTR_ENCODER_COUNT_EN
    ,
    output logic [15:0] instr_count
`endif
);
    logic [31:0] mem [2];
    logic        rp, wp;
    logic [1:0]  cnt;
    logic [31:0] word;
    logic        legal, push, pop;

    always_comb begin
        word = in_class == 3'd0 ? {11'b10001011000, in_rm, 6'd0, in_rn, in_rd} :
               in_class == 3'd1 ? {11'b11001011000, in_rm, 6'd0, in_rn, in_rd} :
               in_class == 3'd2 ? {11'b10001010000, in_rm, 6'd0, in_rn, in_rd} :
               in_class == 3'd3 ? {11'b10101010000, in_rm, 6'd0, in_rn, in_rd} :
               in_class == 3'd4 ? {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rd} :
               in_class == 3'd5 ? {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rd} :
               in_class == 3'd6 ? {8'b10110100, in_imm, in_rd} : 32'h0;
        legal     = in_class != 3'b111;
        in_ready  = cnt != 2'd2;
        out_valid = cnt != 2'd0;
        out_instr = out_valid ? mem[rp] : 32'h0;
        push      = in_valid & in_ready & legal;
        pop       = out_valid & out_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rp     <= 1'b0;
            wp     <= 1'b0;
            cnt    <= 2'd0;
            err    <= 1'b0;
        end else begin
            err <= in_valid & in_ready & ~legal;
            if (push) begin
                mem[wp] <= word;
                wp      <= ~wp;
            end
            if (pop)
                rp <= ~rp;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end

`ifdef INSTR_ENCODER_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            instr_count <= 16'd0;
        else if (pop)
            instr_count <= instr_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder; build with INSTR_ENCODER_COUNT_EN to cover the pop counter.
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  in_class = 3'd0;
    logic [4:0]  in_rd = 5'd0, in_rn = 5'd0, in_rm = 5'd0;
    logic [18:0] in_imm = 19'd0;
    logic        in_ready, out_valid, err;
    logic [31:0] out_instr;
`ifdef INSTR_ENCODER_COUNT_EN
    logic [15:0] instr_count;
`endif
    int          passed = 0, total = 0;
    logic [31:0] q [$];

    instr_encoder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .err(err)
`ifdef INSTR_ENCODER_COUNT_EN
        , .instr_count(instr_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] encode(input logic [2:0] c, input logic [4:0] rd, rn, rm, input logic [18:0] imm);
        logic [31:0] r;
        logic [31:0] ops [7] = '{32'h8B000000, 32'hCB000000, 32'h8A000000, 32'hAA000000,
                                 32'hF8400000, 32'hF8000000, 32'hB4000000};
        r = ops[c];
        if (c <= 3'd3) r = r | (32'(rm) << 16) | (32'(rn) << 5) | 32'(rd);
        else if (c <= 3'd5) r = r | (32'(imm[8:0]) << 12) | (32'(rn) << 5) | 32'(rd);
        else r = r | (32'(imm) << 5) | 32'(rd);
        return r;
    endfunction

    // Inputs change just after posedge, so negedge sees exactly what the next edge will act on.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0)
                    $display("FAIL pop_unexpected: got %h, expected no word", out_instr);
                else begin
                    logic [31:0] exp;
                    exp = q.pop_front();
                    if (out_instr !== exp) $display("FAIL pop_word: got %h, expected %h", out_instr, exp);
                    else passed++;
                end
            end
            if (in_valid && in_ready && in_class != 3'b111)
                q.push_back(encode(in_class, in_rd, in_rn, in_rm, in_imm));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] c, input logic [4:0] rd, rn, rm, input logic [18:0] imm);
        in_valid = 1'b1; in_class = c; in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm;
        for (int i = 0; i < 50 && !in_ready; i++) step();
        if (!in_ready) begin
            total++;
            $display("FAIL send_timeout: in_ready got %b, expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        step();
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, expected 1", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, expected 0", out_valid); else passed++;
        total++; if (out_instr !== 32'h0) $display("FAIL reset_out_instr: got %h, expected 0", out_instr); else passed++;
        total++; if (err !== 1'b0) $display("FAIL reset_err: got %b, expected 0", err); else passed++;
`ifdef INSTR_ENCODER_COUNT_EN
        total++; if (instr_count !== 16'd0) $display("FAIL reset_count: got %0d, expected 0", instr_count); else passed++;
`endif
        reset = 1'b0;
        step();
    endtask

    task automatic test_ldur();
        out_ready = 1'b1;
        send(3'd4, 5'd1, 5'd2, 5'd0, 19'd8);
        total++; if (out_valid !== 1'b1) $display("FAIL ldur_valid: got %b, expected 1", out_valid); else passed++;
        total++; if (out_instr !== 32'hF8408041) $display("FAIL ldur_word: got %h, expected F8408041", out_instr); else passed++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL ldur_drained: got %b, expected 0", out_valid); else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        send(3'd0, 5'd3, 5'd1, 5'd2, 19'd0);
        send(3'd6, 5'd5, 5'd0, 5'd0, 19'd4);
        total++; if (in_ready !== 1'b0) $display("FAIL b2b_full: in_ready got %b, expected 0", in_ready); else passed++;
        total++; if (out_instr !== 32'h8B020023) $display("FAIL b2b_head: got %h, expected 8B020023", out_instr); else passed++;
        out_ready = 1'b1;
        step();
        total++; if (out_instr !== 32'hB4000085) $display("FAIL b2b_second: got %h, expected B4000085", out_instr); else passed++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL b2b_empty: got %b, expected 0", out_valid); else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_full();
        logic [31:0] head;
        send(3'd2, 5'd7, 5'd8, 5'd9, 19'd0);
        send(3'd3, 5'd10, 5'd11, 5'd12, 19'd0);
        head = encode(3'd2, 5'd7, 5'd8, 5'd9, 19'd0);
        in_valid = 1'b1; in_class = 3'd5; in_rd = 5'd9; in_rn = 5'd0; in_rm = 5'd0; in_imm = 19'd0;
        step(); step(); step();
        total++; if (in_ready !== 1'b0) $display("FAIL full_blocked: in_ready got %b, expected 0", in_ready); else passed++;
        total++; if (out_instr !== head) $display("FAIL full_stable: got %h, expected %h", out_instr, head); else passed++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b1) $display("FAIL full_after_pop: in_ready got %b, expected 1", in_ready); else passed++;
        step();
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) $display("FAIL full_stur_taken: in_ready got %b, expected 0", in_ready); else passed++;
        out_ready = 1'b1;
        step();
        total++; if (out_instr !== 32'hF8000009) $display("FAIL full_stur_word: got %h, expected F8000009", out_instr); else passed++;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_illegal();
        in_valid = 1'b1; in_class = 3'b111;
        step();
        in_valid = 1'b0;
        total++; if (err !== 1'b1) $display("FAIL illegal_err: got %b, expected 1", err); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL illegal_valid: got %b, expected 0", out_valid); else passed++;
        step();
        total++; if (err !== 1'b0) $display("FAIL illegal_pulse: got %b, expected 0", err); else passed++;
        send(3'd1, 5'd2, 5'd3, 5'd4, 19'd0);
        in_valid = 1'b1; in_class = 3'b111;
        step();
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b1) $display("FAIL illegal_count: in_ready got %b, expected 1", in_ready); else passed++;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || err !== 1'b1) $display("FAIL illegal_with_pop: valid/err got %b%b, expected 01", out_valid, err); else passed++;
        step();
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        send(3'd1, 5'd1, 5'd1, 5'd1, 19'd0);
        total++; if (out_instr !== 32'hCB010021) $display("FAIL mid_sub: got %h, expected CB010021", out_instr); else passed++;
        #2 reset = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || out_instr !== 32'h0) $display("FAIL mid_async: valid %b instr %h, expected 0 0", out_valid, out_instr); else passed++;
        q.delete();
        step();
        reset = 1'b0;
        step();
        send(3'd3, 5'd4, 5'd5, 5'd6, 19'd0);
        exp = encode(3'd3, 5'd4, 5'd5, 5'd6, 19'd0);
        total++; if (out_instr !== exp) $display("FAIL mid_next: got %h, expected %h", out_instr, exp); else passed++;
        out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL mid_alone: got %b, expected 0", out_valid); else passed++;
        out_ready = 1'b0;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_class = 3'($urandom_range(0, 6));
            in_rd = 5'($urandom); in_rn = 5'($urandom); in_rm = 5'($urandom); in_imm = 19'($urandom);
            step();
            total++; if (in_ready !== 1'b1) $display("FAIL stream_ready: cycle %0d got %b, expected 1", i, in_ready); else passed++;
        end
        in_valid = 1'b0;
        step(); step();
        total++; if (out_valid !== 1'b0 || q.size() != 0) $display("FAIL stream_drain: valid %b left %0d, expected 0 0", out_valid, q.size()); else passed++;
        out_ready = 1'b0;
    endtask

`ifdef INSTR_ENCODER_COUNT_EN
    task automatic test_count();
        reset = 1'b1;
        q.delete();
        step();
        reset = 1'b0;
        step();
        out_ready = 1'b1;
        send(3'd0, 5'd1, 5'd2, 5'd3, 19'd0);
        send(3'd4, 5'd4, 5'd5, 5'd0, 19'd16);
        send(3'd6, 5'd6, 5'd0, 5'd0, 19'd100);
        send(3'd7, 5'd0, 5'd0, 5'd0, 19'd0);
        step(); step();
        total++; if (instr_count !== 16'd3) $display("FAIL count_pops: got %0d, expected 3", instr_count); else passed++;
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_ldur();
        test_back_to_back();
        test_full();
        test_illegal();
        test_reset_mid();
        test_stream();
`ifdef INSTR_ENCODER_COUNT_EN
        test_count();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
